// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: extracts and extends RV32I/RV64I immediates and
// buffers {imm, err, tag} in a 2-entry elastic FIFO with valid/ready handshakes.
module imm_gen_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic             err_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      base_c;
  logic [XLEN-1:0]  imm_c;
  logic             err_c;
  logic             push_c;
  logic             pop_c;
  logic             unused_opcode;

  // Opcode bits carry no immediate information in any format.
  assign unused_opcode = ^in_instr[6:0];

  // Build a 32-bit immediate, then sign-extend to XLEN (zimm has bit 31 clear).
  always_comb begin
    base_c = '0;
    err_c  = 1'b0;
    case (in_fmt)
      FMT_R: base_c = '0;
      FMT_I: base_c = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: base_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: base_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: base_c = {in_instr[31:12], 12'b0};
      FMT_J: base_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z: base_c = {27'b0, in_instr[19:15]};
      default: begin
        base_c = '0;
        err_c  = 1'b1;
      end
    endcase
    imm_c = XLEN'($signed(base_c));
  end

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;

  assign out_imm = imm_q[rd_ptr];
  assign out_err = err_q[rd_ptr];
  assign out_tag = tag_q[rd_ptr];

  // Entry storage; a beat offered during flush is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        imm_q[i] <= '0;
        err_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (push_c && !flush) begin
      imm_q[wr_ptr] <= imm_c;
      err_q[wr_ptr] <= err_c;
      tag_q[wr_ptr] <= in_tag;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= ~wr_ptr;
      if (pop_c)  rd_ptr <= ~rd_ptr;
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance
// share stimulus; each task checks its own scenario against hand-computed values.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_fmt;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, v32, err32;
  logic [31:0] imm32, tag32;
  logic        rdy64, v64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int n_checks = 0;
  int n_fail   = 0;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_err(err32), .out_tag(tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_err(err64), .out_tag(tag64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [2:0] fmt, input logic [31:0] tag);
    in_valid = v;
    in_instr = instr;
    in_fmt   = fmt;
    in_tag   = tag;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL reset_valid32 got %b exp 0", v32); end
    n_checks++; if (imm32 !== 32'h0) begin n_fail++; $display("FAIL reset_imm32 got %h exp 0", imm32); end
    n_checks++; if (err32 !== 1'b0 || tag32 !== 32'h0) begin n_fail++; $display("FAIL reset_err_tag32 got %b/%h exp 0/0", err32, tag32); end
    n_checks++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_ready32 got %b exp 1", rdy32); end
    n_checks++; if (v64 !== 1'b0 || imm64 !== 64'h0 || rdy64 !== 1'b1) begin n_fail++; $display("FAIL reset_64 got v=%b imm=%h rdy=%b exp 0/0/1", v64, imm64, rdy64); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_i_type();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd1, 32'h100);
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b1) begin n_fail++; $display("FAIL i_valid got %b exp 1", v32); end
    n_checks++; if (imm32 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL i_imm got %h exp ffffffff", imm32); end
    n_checks++; if (tag32 !== 32'h100 || err32 !== 1'b0) begin n_fail++; $display("FAIL i_tag_err got %h/%b exp 100/0", tag32, err32); end
    n_checks++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL i_imm64 got %h exp ffffffffffffffff", imm64); end
    step();
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL i_drain got %b exp 0", v32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4] = '{32'hFE112E23, 32'h00000463, 32'hFFDFF06F, 32'h000FD073};
    logic [2:0]  fmts   [4] = '{3'd2, 3'd3, 3'd5, 3'd6};
    logic [31:0] exps   [4] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h0000001F};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, instrs[k], fmts[k], 32'h200 + 32'(k));
      step();
      n_checks++;
      if (v32 !== 1'b1 || imm32 !== exps[k] || tag32 !== 32'h200 + 32'(k) || err32 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d got v=%b imm=%h tag=%h err=%b exp 1/%h/%h/0", k, v32, imm32, tag32, err32, exps[k], 32'h200 + 32'(k));
      end
    end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    step();
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", v32); end
  endtask

  task automatic test_u_and_illegal();
    out_ready = 1'b1;
    drive(1'b1, 32'h800000B7, 3'd4, 32'h300);
    step();
    n_checks++; if (imm64 !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL u64_neg got %h exp ffffffff80000000", imm64); end
    n_checks++; if (imm32 !== 32'h80000000) begin n_fail++; $display("FAIL u32_neg got %h exp 80000000", imm32); end
    drive(1'b1, 32'h123450B7, 3'd4, 32'h301);
    step();
    n_checks++; if (imm64 !== 64'h0000000012345000) begin n_fail++; $display("FAIL u64_pos got %h exp 0000000012345000", imm64); end
    drive(1'b1, 32'hDEADBEEF, 3'd7, 32'h302);
    step();
    n_checks++; if (imm64 !== 64'h0 || err64 !== 1'b1 || tag64 !== 32'h302) begin n_fail++; $display("FAIL illegal64 got imm=%h err=%b tag=%h exp 0/1/302", imm64, err64, tag64); end
    n_checks++; if (imm32 !== 32'h0 || err32 !== 1'b1) begin n_fail++; $display("FAIL illegal32 got imm=%h err=%b exp 0/1", imm32, err32); end
    drive(1'b1, 32'h00000013, 3'd0, 32'h303);
    step();
    n_checks++; if (imm32 !== 32'h0 || err32 !== 1'b0) begin n_fail++; $display("FAIL r_type got imm=%h err=%b exp 0/0", imm32, err32); end
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd1, 32'hA);
    step();
    n_checks++; if (rdy32 !== 1'b1 || v32 !== 1'b1) begin n_fail++; $display("FAIL bp_after_a got rdy=%b v=%b exp 1/1", rdy32, v32); end
    drive(1'b1, 32'h00200093, 3'd1, 32'hB);
    step();
    n_checks++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", rdy32); end
    drive(1'b1, 32'h00300093, 3'd1, 32'hC);
    step();
    n_checks++; if (rdy32 !== 1'b0 || imm32 !== 32'd1 || tag32 !== 32'hA) begin n_fail++; $display("FAIL bp_hold got rdy=%b imm=%h tag=%h exp 0/1/a", rdy32, imm32, tag32); end
    out_ready = 1'b1;
    step();
    n_checks++; if (v32 !== 1'b1 || imm32 !== 32'd2 || tag32 !== 32'hB || rdy32 !== 1'b1) begin n_fail++; $display("FAIL bp_b got v=%b imm=%h tag=%h rdy=%b exp 1/2/b/1", v32, imm32, tag32, rdy32); end
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b1 || imm32 !== 32'd3 || tag32 !== 32'hC) begin n_fail++; $display("FAIL bp_c got v=%b imm=%h tag=%h exp 1/3/c", v32, imm32, tag32); end
    step();
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b exp 0", v32); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 3'd1, 32'hD);
    step();
    drive(1'b1, 32'h00500093, 3'd1, 32'hE);
    step();
    drive(1'b1, 32'h00600093, 3'd1, 32'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b0 || rdy32 !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%b rdy=%b exp 0/1", v32, rdy32); end
    out_ready = 1'b1;
    step();
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL flush_ghost got %b exp 0", v32); end
    // Flush with an empty buffer must also override an accepted push.
    drive(1'b1, 32'h00700093, 3'd1, 32'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL flush_push got %b exp 0", v32); end
    drive(1'b1, 32'h00800093, 3'd1, 32'h88);
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b1 || imm32 !== 32'd8 || tag32 !== 32'h88) begin n_fail++; $display("FAIL flush_resume got v=%b imm=%h tag=%h exp 1/8/88", v32, imm32, tag32); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h7FF00093, 3'd1, 32'h55);
    step();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    n_checks++; if (v32 !== 1'b1 || imm32 !== 32'h7FF) begin n_fail++; $display("FAIL ares_pre got v=%b imm=%h exp 1/7ff", v32, imm32); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (v32 !== 1'b0 || imm32 !== 32'h0 || tag32 !== 32'h0) begin n_fail++; $display("FAIL ares_now got v=%b imm=%h tag=%h exp 0/0/0", v32, imm32, tag32); end
    n_checks++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL ares_ready got %b exp 1", rdy32); end
    rst_n = 1'b1;
    step();
    n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL ares_restart got %b exp 0", v32); end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    test_reset();
    test_i_type();
    test_back_to_back();
    test_u_and_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
